// File: rtl/eep_loader_pkg.sv
// Shared types and command-word layout for the EEPROM configuration loader.
package eep_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    GUARD,
    POLL,
    STORE,
    FIN
  } state_e;

  localparam int INST_MSB = 31;
  localparam int INST_LSB = 28;
  localparam int ADDR_MSB = 23;
  localparam int ADDR_LSB = 8;
  localparam int DONE_BIT = 31;

  localparam logic [3:0] RD_INST_DEF = 4'h3;

  function automatic logic [31:0] rd_cmd(input logic [3:0] inst, input logic [15:0] addr);
    logic [31:0] c;
    c = '0;
    c[INST_MSB:INST_LSB] = inst;
    c[ADDR_MSB:ADDR_LSB] = addr;
    return c;
  endfunction

endpackage

// File: rtl/eep_word_packer.sv
// Little-endian byte-to-word packer with optional running checksum
// (checksum built only when EEP_LOADER_CHKSUM_EN is defined).
module eep_word_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        ins,
  input  logic        flush,
  input  logic [1:0]  lane,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_o,
  output logic        chk_fail_o
);

  logic [31:0] buf_q, buf_d;

  // word_o is the buffer with the incoming byte merged in; a flushed word
  // leaves the buffer empty so unfilled lanes of the next word read as 0.
  always_comb begin
    word_o = buf_q;
    word_o[{lane, 3'b000} +: 8] = byte_in;
    buf_d = buf_q;
    if (clr) begin
      buf_d = '0;
    end else if (ins) begin
      buf_d = flush ? '0 : word_o;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_q <= '0;
    end else begin
      buf_q <= buf_d;
    end
  end

`ifdef EEP_LOADER_CHKSUM_EN
  logic [7:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (clr) begin
      sum_d = '0;
    end else if (ins) begin
      sum_d = sum_q + byte_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign chk_fail_o = (sum_q != 8'd0);
`else
  assign chk_fail_o = 1'b0;
`endif

endmodule

// File: rtl/eeprom_cfg_loader.sv
// Boot-time EEPROM block reader that packs bytes into 32-bit config words.
// Optional block checksum check enabled by defining EEP_LOADER_CHKSUM_EN.
module eeprom_cfg_loader
  import eep_loader_pkg::*;
#(
  parameter logic [3:0] RD_INST     = RD_INST_DEF,
  parameter int         TIMEOUT_CYC = 100000,
  parameter int         GUARD_CYC   = 2
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST_N,
  input  logic        START,
  input  logic [15:0] BASE_ADDR,
  input  logic [9:0]  BYTE_CNT,
  output logic        BUSY,
  output logic        DONE,
  output logic        ERR,
  output logic        CHK_ERR,
  output logic [31:0] EEP_DI,
  output logic        EEP_WE,
  output logic        EEP_RE,
  input  logic [31:0] EEP_DO,
  output logic        WR_EN,
  output logic [7:0]  WR_ADDR,
  output logic [31:0] WR_DATA
);

  localparam logic [19:0] TMO_LAST   = 20'(TIMEOUT_CYC - 1);
  localparam logic [2:0]  GUARD_LAST = 3'(GUARD_CYC - 1);

  state_e      state_q, state_d;
  logic [15:0] base_q, base_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [9:0]  idx_q, idx_d;
  logic [19:0] tmo_q, tmo_d;
  logic [2:0]  guard_q, guard_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d, chk_err_q, chk_err_d;
  logic        eep_we_q, eep_we_d, eep_re_q, eep_re_d, wr_en_q, wr_en_d;
  logic [31:0] eep_di_q, eep_di_d, wr_data_q, wr_data_d;
  logic [7:0]  wr_addr_q, wr_addr_d;

  logic        pk_clr, pk_ins, pk_flush, pk_chk_fail, is_last;
  logic [31:0] pk_word;
  logic        unused_do;

  assign unused_do = &{1'b0, EEP_DO[30:8]};
  assign is_last   = (idx_q == cnt_q - 10'd1);

  eep_word_packer u_packer (
    .clk       (OPB_CLK),
    .rst_n     (OPB_RST_N),
    .clr       (pk_clr),
    .ins       (pk_ins),
    .flush     (pk_flush),
    .lane      (idx_q[1:0]),
    .byte_in   (EEP_DO[7:0]),
    .word_o    (pk_word),
    .chk_fail_o(pk_chk_fail)
  );

  // Outputs are derived from the next state so every port comes straight off a flop.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    tmo_d     = tmo_q;
    guard_d   = guard_q;
    err_d     = err_q;
    chk_err_d = chk_err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    eep_di_d  = eep_di_q;
    pk_clr    = 1'b0;
    pk_ins    = 1'b0;
    pk_flush  = 1'b0;

    case (state_q)
      IDLE: begin
        if (START) begin
          err_d     = 1'b0;
          chk_err_d = 1'b0;
          pk_clr    = 1'b1;
          if (BYTE_CNT != 10'd0) begin
            base_d  = BASE_ADDR;
            cnt_d   = BYTE_CNT;
            idx_d   = '0;
            tmo_d   = '0;
            state_d = ISSUE;
          end else begin
            state_d = FIN;
          end
        end
      end
      ISSUE: begin
        guard_d = '0;
        state_d = GUARD;
      end
      GUARD: begin
        if (guard_q == GUARD_LAST) begin
          tmo_d   = '0;
          state_d = POLL;
        end else begin
          guard_d = guard_q + 3'd1;
        end
      end
      POLL: begin
        if (EEP_DO[DONE_BIT]) begin
          pk_ins    = 1'b1;
          pk_flush  = (idx_q[1:0] == 2'd3) || is_last;
          wr_en_d   = pk_flush;
          wr_addr_d = idx_q[9:2];
          wr_data_d = pk_word;
          state_d   = STORE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          tmo_d = tmo_q + 20'd1;
        end
      end
      STORE: begin
        if (is_last) begin
          chk_err_d = pk_chk_fail;
          state_d   = FIN;
        end else begin
          idx_d   = idx_q + 10'd1;
          tmo_d   = '0;
          state_d = ISSUE;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d   = state_d inside {ISSUE, GUARD, POLL, STORE};
    done_d   = (state_d == FIN);
    eep_we_d = (state_d == ISSUE);
    eep_re_d = (state_d == POLL);
    if (state_d == ISSUE) begin
      eep_di_d = rd_cmd(RD_INST, base_d + {6'd0, idx_d});
    end
  end

  always_ff @(posedge OPB_CLK) begin
    if (!OPB_RST_N) begin
      state_q   <= IDLE;
      base_q    <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      tmo_q     <= '0;
      guard_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      chk_err_q <= 1'b0;
      eep_we_q  <= 1'b0;
      eep_re_q  <= 1'b0;
      eep_di_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      tmo_q     <= tmo_d;
      guard_q   <= guard_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      chk_err_q <= chk_err_d;
      eep_we_q  <= eep_we_d;
      eep_re_q  <= eep_re_d;
      eep_di_q  <= eep_di_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign ERR     = err_q;
  assign CHK_ERR = chk_err_q;
  assign EEP_DI  = eep_di_q;
  assign EEP_WE  = eep_we_q;
  assign EEP_RE  = eep_re_q;
  assign WR_EN   = wr_en_q;
  assign WR_ADDR = wr_addr_q;
  assign WR_DATA = wr_data_q;

endmodule

// File: tb/tb_eeprom_cfg_loader.sv
// Directed bench for eeprom_cfg_loader with a simple EEPROM status model.
module tb_eeprom_cfg_loader;

  localparam int MODEL_LAT = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] base_addr = '0;
  logic [9:0]  byte_cnt = '0;
  logic        busy, done, err, chk_err, eep_we, eep_re, wr_en;
  logic [31:0] eep_di, wr_data;
  logic [31:0] eep_do = '0;
  logic [7:0]  wr_addr;

  eeprom_cfg_loader #(.TIMEOUT_CYC(50), .GUARD_CYC(2)) dut (
    .OPB_CLK  (clk),
    .OPB_RST_N(rst_n),
    .START    (start),
    .BASE_ADDR(base_addr),
    .BYTE_CNT (byte_cnt),
    .BUSY     (busy),
    .DONE     (done),
    .ERR      (err),
    .CHK_ERR  (chk_err),
    .EEP_DI   (eep_di),
    .EEP_WE   (eep_we),
    .EEP_RE   (eep_re),
    .EEP_DO   (eep_do),
    .WR_EN    (wr_en),
    .WR_ADDR  (wr_addr),
    .WR_DATA  (wr_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Monitor logs and EEPROM model state
  logic [31:0] we_log[$];
  logic [39:0] wr_log[$];
  int          done_cnt = 0, re_cyc = 0, overlap = 0;
  logic        err_at_done = 1'b0, chk_at_done = 1'b0, busy_at_done = 1'b0;
  int          m_cnt = 0;
  logic [7:0]  m_byte = '0;
  logic        m_hang = 1'b0, use_tbl = 1'b0;
  logic [7:0]  tbl[4];

  always @(negedge clk) begin
    if (eep_we) we_log.push_back(eep_di);
    if (wr_en) wr_log.push_back({wr_addr, wr_data});
    if (eep_we && wr_en) overlap++;
    if (eep_re) re_cyc++;
    if (done) begin
      done_cnt++;
      err_at_done  = err;
      chk_at_done  = chk_err;
      busy_at_done = busy;
    end
    if (!rst_n) begin
      m_cnt  = 0;
      eep_do = '0;
    end else if (eep_we) begin
      if (use_tbl && we_log.size() <= 4) m_byte = tbl[we_log.size() - 1];
      else m_byte = eep_di[15:8];
      m_cnt  = MODEL_LAT;
      eep_do = '0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0 && !m_hang) eep_do = {1'b1, 23'd0, m_byte};
    end
  end

  function automatic logic [39:0] wr_at(input int i);
    return (i < wr_log.size()) ? wr_log[i] : 40'hFF_FFFF_FFFF;
  endfunction

  function automatic logic [31:0] we_at(input int i);
    return (i < we_log.size()) ? we_log[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] cmd(input logic [15:0] a);
    return {4'h3, 4'h0, a, 8'h00};
  endfunction

  task automatic clear_logs();
    we_log.delete();
    wr_log.delete();
    done_cnt = 0;
    re_cyc   = 0;
    overlap  = 0;
  endtask

  task automatic pulse_start(input logic [15:0] b, input logic [9:0] c);
    @(posedge clk); #1;
    base_addr = b;
    byte_cnt  = c;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int cyc = 0;
    while (done_cnt == 0 && cyc < bound) begin
      @(posedge clk); #1;
      cyc++;
    end
    check_val("done_seen", 64'(done_cnt), 64'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ctrl", {busy, done, err, chk_err, eep_we, eep_re, wr_en}, 0);
    check_val("rst_eep_di", eep_di, 0);
    check_val("rst_wr", {wr_addr, wr_data}, 0);
    rst_n = 1'b1;

    // 8-byte aligned load
    clear_logs();
    pulse_start(16'h0100, 10'd8);
    check_val("busy_after_start", busy, 1);
    wait_done(3000);
    check_val("a8_we_cnt", we_log.size(), 8);
    for (int i = 0; i < 8; i++) check_val($sformatf("a8_cmd%0d", i), we_at(i), cmd(16'h0100 + 16'(i)));
    check_val("a8_wr_cnt", wr_log.size(), 2);
    check_val("a8_wr0", wr_at(0), {8'h00, 32'h03020100});
    check_val("a8_wr1", wr_at(1), {8'h01, 32'h07060504});
    check_val("a8_err", err_at_done, 0);
    check_val("a8_busy_at_done", busy_at_done, 0);
    check_val("a8_overlap", overlap, 0);
`ifndef EEP_LOADER_CHKSUM_EN
    check_val("a8_chk_tied", chk_at_done, 0);
`endif
    repeat (5) @(posedge clk);
    check_val("a8_single_done", done_cnt, 1);

    // 5-byte load: partial final word
    clear_logs();
    pulse_start(16'h0100, 10'd5);
    wait_done(3000);
    check_val("p5_wr_cnt", wr_log.size(), 2);
    check_val("p5_wr1", wr_at(1), {8'h01, 32'h00000004});

    // address wrap
    clear_logs();
    pulse_start(16'hFFFE, 10'd4);
    wait_done(3000);
    check_val("wrap_cmd0", we_at(0), cmd(16'hFFFE));
    check_val("wrap_cmd1", we_at(1), cmd(16'hFFFF));
    check_val("wrap_cmd2", we_at(2), cmd(16'h0000));
    check_val("wrap_cmd3", we_at(3), cmd(16'h0001));
    check_val("wrap_wr0", wr_at(0), {8'h00, 32'h0100FFFE});

    // timeout
    clear_logs();
    m_hang = 1'b1;
    pulse_start(16'h0300, 10'd2);
    wait_done(3000);
    check_val("tmo_re_cyc", re_cyc, 50);
    check_val("tmo_err", err_at_done, 1);
    check_val("tmo_wr_cnt", wr_log.size(), 0);
    check_val("tmo_we_cnt", we_log.size(), 1);
    check_val("tmo_err_held", err, 1);
    m_hang = 1'b0;
    clear_logs();
    pulse_start(16'h0042, 10'd1);
    check_val("tmo_err_cleared", err, 0);
    wait_done(3000);
    check_val("tmo_next_err", err_at_done, 0);
    check_val("tmo_next_wr0", wr_at(0), {8'h00, 32'h00000042});

    // zero-length load
    clear_logs();
    pulse_start(16'h0500, 10'd0);
    check_val("zero_done_now", {done, busy}, 2'b10);
    repeat (4) @(posedge clk);
    #1;
    check_val("zero_done_cnt", done_cnt, 1);
    check_val("zero_we_cnt", we_log.size(), 0);
    check_val("zero_wr_cnt", wr_log.size(), 0);

    // START while busy is ignored
    clear_logs();
    pulse_start(16'h0010, 10'd4);
    repeat (10) @(posedge clk);
    pulse_start(16'h2000, 10'd2);
    wait_done(3000);
    check_val("ign_we_cnt", we_log.size(), 4);
    check_val("ign_cmd3", we_at(3), cmd(16'h0013));
    check_val("ign_wr0", wr_at(0), {8'h00, 32'h13121110});
    repeat (200) @(posedge clk);
    check_val("ign_done_cnt", done_cnt, 1);

    // reset mid-load
    clear_logs();
    pulse_start(16'h0200, 10'd8);
    repeat (30) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_val("mrst_ctrl", {busy, done, err, chk_err, eep_we, eep_re, wr_en}, 0);
    check_val("mrst_data", {eep_di, wr_addr, wr_data}, 0);
    rst_n = 1'b1;
    repeat (400) @(posedge clk);
    check_val("mrst_no_done", done_cnt, 0);

`ifdef EEP_LOADER_CHKSUM_EN
    use_tbl = 1'b1;
    tbl[0] = 8'h10; tbl[1] = 8'h20; tbl[2] = 8'h30; tbl[3] = 8'hA0;
    clear_logs();
    pulse_start(16'h0000, 10'd4);
    wait_done(3000);
    check_val("chk_good", chk_at_done, 0);
    check_val("chk_good_wr0", wr_at(0), {8'h00, 32'hA0302010});
    tbl[3] = 8'hA1;
    clear_logs();
    pulse_start(16'h0000, 10'd4);
    wait_done(3000);
    check_val("chk_bad", chk_at_done, 1);
    use_tbl = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
